aurora_link_sequencer: RTL and testbench
========================================

AURORA_LINK_SEQUENCER -- requirements
Module: aurora_link_sequencer

Interface
REQ-001 SHALL have parameter GT_RST_CYCLES, default 65536: cycles gt_rst_o is held asserted per attempt.
REQ-002 SHALL have parameter AURORA_RST_CYCLES, default 131072: cycles aurora_rst_o is held after pll lock.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 100000: cycles allowed for pll lock.
REQ-004 SHALL have parameter UP_TIMEOUT, default 1000000: cycles allowed for channel up.
REQ-005 SHALL have parameter MAX_RETRY, default 7: failed attempts allowed before FAIL (range 1..15).
REQ-006 SHALL have port clk_100m, input, 1: sole clock.
REQ-007 SHALL have port nrst_i, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port pll_lock_i, input, 1: GT PLL lock, asynchronous to clk_100m.
REQ-009 SHALL have port channel_up_i, input, 1: Aurora channel up, asynchronous to clk_100m.
REQ-010 SHALL have port relink_i, input, 1: single-cycle software restart request, synchronous.
REQ-011 SHALL have port gt_rst_o, output, 1: GT reset, active-high, registered.
REQ-012 SHALL have port aurora_rst_o, output, 1: Aurora reset, active-high, registered.
REQ-013 SHALL have port link_ready_o, output, 1: high only in LINK_UP.
REQ-014 SHALL have port link_fail_o, output, 1: high only in FAIL.
REQ-015 SHALL have port retry_cnt_o, output, 4: failed attempts since last clear.
REQ-016 SHALL have port state_o, output, 3: current state encoding, for debug.

Function
REQ-017 SHALL pass pll_lock_i and channel_up_i through two-flop synchronizers; the FSM uses only the synchronized versions (2-cycle latency).
REQ-018 SHALL implement states GT_RST=0, WAIT_LOCK=1, AUR_RST=2, WAIT_UP=3, LINK_UP=4, FAIL=5; any other encoding SHALL go to GT_RST on the next cycle.
REQ-019 SHALL use a single down-counter, 21 bits wide, loaded on every state entry with the new state's limit minus 1.
REQ-020 GT_RST: gt_rst_o=1 and aurora_rst_o=1; when the counter reaches 0, go to WAIT_LOCK.
REQ-021 WAIT_LOCK: gt_rst_o=0 and aurora_rst_o=1; on sync lock go to AUR_RST; on counter 0 without lock, count a failure (REQ-025).
REQ-022 AUR_RST: aurora_rst_o=1; loss of sync lock counts a failure; on counter 0 go to WAIT_UP.
REQ-023 WAIT_UP: aurora_rst_o=0; on sync channel_up go to LINK_UP; on counter 0 or loss of lock, count a failure.
REQ-024 LINK_UP: both resets 0 and link_ready_o=1; a fall of sync channel_up or sync lock counts a failure.
REQ-025 On a failure, retry_cnt increments (saturating at 15). The next state is FAIL if the incremented value is at least MAX_RETRY, otherwise GT_RST.
REQ-026 FAIL: both resets 1 and link_fail_o=1; stay in FAIL until relink_i.
REQ-027 relink_i in any state SHALL go to GT_RST the next cycle and clear retry_cnt to 0; relink_i takes priority over every other transition in the same cycle.
REQ-028 A failure and a success condition in the same cycle SHALL be treated as the failure.
REQ-029 All outputs SHALL be decoded from the next state and registered, so outputs change on the same edge as the state.

Reset
REQ-030 While nrst_i=0: state=GT_RST, counter=GT_RST_CYCLES-1, retry_cnt=0, gt_rst_o=1, aurora_rst_o=1, link_ready_o=0, link_fail_o=0, synchronizer flops=0.
REQ-031 Reset assertion SHALL take effect asynchronously; deassertion is externally synchronized to clk_100m.
REQ-032 A mid-sequence reset SHALL abort the attempt with no residual state carried over.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the counter width constant (21), and the default timing constants.
REQ-034 The single sub-module SHALL be sync_2ff, instantiated once per asynchronous input.

Verification (GT_RST_CYCLES=16, AURORA_RST_CYCLES=32, LOCK_TIMEOUT=64, UP_TIMEOUT=128, MAX_RETRY=3)
REQ-035 Nominal: lock at cycle 20, channel_up 10 cycles after aurora_rst_o falls -> gt_rst_o falls at cycle 16; aurora_rst_o falls 32 cycles after sync lock; link_ready_o rises 2-3 cycles after channel_up; retry_cnt_o=0.
REQ-036 Lock never asserts -> three 80-cycle attempts; retry_cnt_o=1,2,3; then FAIL with link_fail_o=1 and both resets 1.
REQ-037 In LINK_UP, channel_up drops for 1 cycle -> within 3 cycles the state returns to GT_RST, link_ready_o=0, retry_cnt_o=1.
REQ-038 In FAIL, pulse relink_i -> next cycle state_o=0 and retry_cnt_o=0; nominal stimulus then reaches LINK_UP.
REQ-039 nrst_i low for 1 cycle during WAIT_UP -> immediate reset values; the sequence restarts with a full 16-cycle gt_rst_o.

Source files
------------

// File: rtl/aurora_link_sequencer_pkg.sv
// Shared definitions for the Aurora link bring-up sequencer.
// It holds the state encoding (also exported on state_o for debug), the
// width of the shared timeout counter, the default timing constants and a
// saturating increment for the 4-bit retry counter.
package aurora_link_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_GT_RST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_AUR_RST   = 3'd2,
        ST_WAIT_UP   = 3'd3,
        ST_LINK_UP   = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam int CNT_W = 21;

    localparam int DEF_GT_RST_CYCLES     = 65536;
    localparam int DEF_AURORA_RST_CYCLES = 131072;
    localparam int DEF_LOCK_TIMEOUT      = 100000;
    localparam int DEF_UP_TIMEOUT        = 1000000;
    localparam int DEF_MAX_RETRY         = 7;

    // The retry counter stops at 15 instead of wrapping back to 0.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        sat_inc4 = (v == 4'd15) ? 4'd15 : (v + 4'd1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk (destination clock), rst_n (async active-low, clears both
// flops), d (asynchronous input), q (synchronized output, 2-cycle latency).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture chain. Only meta_r may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/aurora_link_sequencer.sv
// Aurora link bring-up sequencer. It sequences the GT reset, waits for PLL
// lock, sequences the Aurora reset and waits for channel up. A failed attempt
// is retried until MAX_RETRY failures have accumulated, and then the block
// parks in FAIL.
// Ports: clk_100m (clock), nrst_i (async active-low reset), pll_lock_i and
// channel_up_i (async status inputs), relink_i (sync restart pulse),
// gt_rst_o and aurora_rst_o (active-high resets), link_ready_o, link_fail_o,
// retry_cnt_o (failed attempts), state_o (debug state encoding).
module aurora_link_sequencer
    import aurora_link_sequencer_pkg::*;
#(
    parameter int GT_RST_CYCLES     = DEF_GT_RST_CYCLES,
    parameter int AURORA_RST_CYCLES = DEF_AURORA_RST_CYCLES,
    parameter int LOCK_TIMEOUT      = DEF_LOCK_TIMEOUT,
    parameter int UP_TIMEOUT        = DEF_UP_TIMEOUT,
    parameter int MAX_RETRY         = DEF_MAX_RETRY
) (
    input  logic       clk_100m,
    input  logic       nrst_i,
    input  logic       pll_lock_i,
    input  logic       channel_up_i,
    input  logic       relink_i,
    output logic       gt_rst_o,
    output logic       aurora_rst_o,
    output logic       link_ready_o,
    output logic       link_fail_o,
    output logic [3:0] retry_cnt_o,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] GT_LOAD   = CNT_W'(GT_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] AUR_LOAD  = CNT_W'(AURORA_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] UP_LOAD   = CNT_W'(UP_TIMEOUT - 1);
    localparam logic [3:0]       MAX_RETRY_L = 4'(MAX_RETRY);

    logic             lock_sync_s;
    logic             up_sync_s;
    state_t           state_r;
    state_t           state_next_s;
    state_t           target_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [3:0]       retry_r;
    logic [3:0]       retry_next_s;
    logic [3:0]       retry_inc_s;
    logic             fail_s;
    logic             take_s;
    logic             cnt_zero_s;
    logic             gt_rst_r;
    logic             aurora_rst_r;
    logic             link_ready_r;
    logic             link_fail_r;

    sync_2ff u_sync_lock (
        .clk   (clk_100m),
        .rst_n (nrst_i),
        .d     (pll_lock_i),
        .q     (lock_sync_s)
    );

    sync_2ff u_sync_up (
        .clk   (clk_100m),
        .rst_n (nrst_i),
        .d     (channel_up_i),
        .q     (up_sync_s)
    );

    // Next-state, counter and retry decisions. The priority is relink, then
    // failure, then success.
    always_comb begin
        fail_s       = 1'b0;
        take_s       = 1'b0;
        target_s     = state_r;
        cnt_zero_s   = (cnt_r == {CNT_W{1'b0}});
        retry_inc_s  = sat_inc4(retry_r);
        state_next_s = state_r;
        retry_next_s = retry_r;
        cnt_next_s   = cnt_zero_s ? cnt_r : (cnt_r - {{(CNT_W-1){1'b0}}, 1'b1});

        case (state_r)
            ST_GT_RST: begin
                if (cnt_zero_s) begin
                    take_s   = 1'b1;
                    target_s = ST_WAIT_LOCK;
                end else begin
                    take_s = 1'b0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_s) begin
                    take_s   = 1'b1;
                    target_s = ST_AUR_RST;
                end else if (cnt_zero_s) begin
                    fail_s = 1'b1;
                end else begin
                    take_s = 1'b0;
                end
            end
            ST_AUR_RST: begin
                if (!lock_sync_s) begin
                    fail_s = 1'b1;
                end else if (cnt_zero_s) begin
                    take_s   = 1'b1;
                    target_s = ST_WAIT_UP;
                end else begin
                    take_s = 1'b0;
                end
            end
            ST_WAIT_UP: begin
                // A timeout in the same cycle as channel up still counts as a failure.
                if (!lock_sync_s || cnt_zero_s) begin
                    fail_s = 1'b1;
                end else if (up_sync_s) begin
                    take_s   = 1'b1;
                    target_s = ST_LINK_UP;
                end else begin
                    take_s = 1'b0;
                end
            end
            ST_LINK_UP: begin
                if (!lock_sync_s || !up_sync_s) begin
                    fail_s = 1'b1;
                end else begin
                    fail_s = 1'b0;
                end
            end
            ST_FAIL: begin
                take_s = 1'b0;
            end
            default: begin
                take_s   = 1'b1;
                target_s = ST_GT_RST;
            end
        endcase

        if (relink_i) begin
            state_next_s = ST_GT_RST;
            retry_next_s = 4'd0;
        end else if (fail_s) begin
            retry_next_s = retry_inc_s;
            state_next_s = (retry_inc_s >= MAX_RETRY_L) ? ST_FAIL : ST_GT_RST;
        end else if (take_s) begin
            state_next_s = target_s;
        end else begin
            state_next_s = state_r;
        end

        // Every state entry, including re-entry of GT_RST on relink, reloads the counter.
        if (relink_i || fail_s || take_s) begin
            case (state_next_s)
                ST_GT_RST:    cnt_next_s = GT_LOAD;
                ST_WAIT_LOCK: cnt_next_s = LOCK_LOAD;
                ST_AUR_RST:   cnt_next_s = AUR_LOAD;
                ST_WAIT_UP:   cnt_next_s = UP_LOAD;
                default:      cnt_next_s = {CNT_W{1'b0}};
            endcase
        end else begin
            cnt_next_s = cnt_next_s;
        end
    end

    // State, counter, retry count and the outputs decoded from the next state.
    always_ff @(posedge clk_100m or negedge nrst_i) begin
        if (!nrst_i) begin
            state_r      <= ST_GT_RST;
            cnt_r        <= GT_LOAD;
            retry_r      <= 4'd0;
            gt_rst_r     <= 1'b1;
            aurora_rst_r <= 1'b1;
            link_ready_r <= 1'b0;
            link_fail_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            retry_r      <= retry_next_s;
            gt_rst_r     <= (state_next_s == ST_GT_RST) || (state_next_s == ST_FAIL);
            aurora_rst_r <= (state_next_s == ST_GT_RST) || (state_next_s == ST_WAIT_LOCK) ||
                            (state_next_s == ST_AUR_RST) || (state_next_s == ST_FAIL);
            link_ready_r <= (state_next_s == ST_LINK_UP);
            link_fail_r  <= (state_next_s == ST_FAIL);
        end
    end

    assign gt_rst_o     = gt_rst_r;
    assign aurora_rst_o = aurora_rst_r;
    assign link_ready_o = link_ready_r;
    assign link_fail_o  = link_fail_r;
    assign retry_cnt_o  = retry_r;
    assign state_o      = state_r;

endmodule

// File: tb/tb_aurora_link_sequencer.sv
// Directed bench for aurora_link_sequencer with reduced timing parameters.
// Expected cycle counts follow from the timing: GT_RST lasts 16 cycles, the
// lock timeout is 64 cycles, AUR_RST lasts 32 cycles, and the synchronizers
// plus the FSM add 3 edges of latency on an input change.
module tb_aurora_link_sequencer;

    logic       clk_100m = 1'b0;
    logic       nrst_i = 1'b0;
    logic       pll_lock_i = 1'b0;
    logic       channel_up_i = 1'b0;
    logic       relink_i = 1'b0;
    logic       gt_rst_o;
    logic       aurora_rst_o;
    logic       link_ready_o;
    logic       link_fail_o;
    logic [3:0] retry_cnt_o;
    logic [2:0] state_o;

    int checks = 0;
    int fails  = 0;

    aurora_link_sequencer #(
        .GT_RST_CYCLES     (16),
        .AURORA_RST_CYCLES (32),
        .LOCK_TIMEOUT      (64),
        .UP_TIMEOUT        (128),
        .MAX_RETRY         (3)
    ) dut (
        .clk_100m     (clk_100m),
        .nrst_i       (nrst_i),
        .pll_lock_i   (pll_lock_i),
        .channel_up_i (channel_up_i),
        .relink_i     (relink_i),
        .gt_rst_o     (gt_rst_o),
        .aurora_rst_o (aurora_rst_o),
        .link_ready_o (link_ready_o),
        .link_fail_o  (link_fail_o),
        .retry_cnt_o  (retry_cnt_o),
        .state_o      (state_o)
    );

    // 100 MHz clock
    always #5 clk_100m = ~clk_100m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100m);
        #1;
    endtask

    // Call this just after GT_RST has been entered with a full count. It
    // checks each stage of a nominal bring-up through to LINK_UP.
    task automatic bring_up(input string tag);
        int n;
        n = 0;
        while (gt_rst_o && n < 1000) begin step(); n++; end
        check_eq({tag, "_gt_rst_len"}, n, 32'd16);
        check_eq({tag, "_wait_lock_state"}, {29'd0, state_o}, 32'd1);
        check_eq({tag, "_aur_rst_held"}, {31'd0, aurora_rst_o}, 32'd1);
        repeat (4) step();
        pll_lock_i = 1'b1;
        n = 0;
        while (state_o != 3'd2 && n < 1000) begin step(); n++; end
        check_eq({tag, "_lock_latency"}, n, 32'd3);
        n = 0;
        while (aurora_rst_o && n < 1000) begin step(); n++; end
        check_eq({tag, "_aur_rst_len"}, n, 32'd32);
        check_eq({tag, "_wait_up_state"}, {29'd0, state_o}, 32'd3);
        repeat (10) step();
        channel_up_i = 1'b1;
        n = 0;
        while (!link_ready_o && n < 1000) begin step(); n++; end
        check_eq({tag, "_up_latency"}, n, 32'd3);
        check_eq({tag, "_link_up_state"}, {29'd0, state_o}, 32'd4);
        check_eq({tag, "_link_up_retry"}, {28'd0, retry_cnt_o}, 32'd0);
        check_eq({tag, "_link_up_gt_rst"}, {31'd0, gt_rst_o}, 32'd0);
        check_eq({tag, "_link_up_aur_rst"}, {31'd0, aurora_rst_o}, 32'd0);
    endtask

    initial begin
        int n;

        // Reset values
        repeat (3) step();
        check_eq("rst_state", {29'd0, state_o}, 32'd0);
        check_eq("rst_gt_rst", {31'd0, gt_rst_o}, 32'd1);
        check_eq("rst_aur_rst", {31'd0, aurora_rst_o}, 32'd1);
        check_eq("rst_ready", {31'd0, link_ready_o}, 32'd0);
        check_eq("rst_fail", {31'd0, link_fail_o}, 32'd0);
        check_eq("rst_retry", {28'd0, retry_cnt_o}, 32'd0);
        @(negedge clk_100m);
        nrst_i = 1'b1;

        // Nominal bring-up
        bring_up("nom");

        // A one-cycle drop of channel_up while in LINK_UP
        channel_up_i = 1'b0;
        step();
        channel_up_i = 1'b1;
        n = 1;
        while (state_o != 3'd0 && n < 10) begin step(); n++; end
        check_eq("drop_latency", n, 32'd3);
        check_eq("drop_ready", {31'd0, link_ready_o}, 32'd0);
        check_eq("drop_retry", {28'd0, retry_cnt_o}, 32'd1);
        check_eq("drop_gt_rst", {31'd0, gt_rst_o}, 32'd1);

        // Relink clears the count; PLL lock then never arrives
        pll_lock_i   = 1'b0;
        channel_up_i = 1'b0;
        relink_i     = 1'b1;
        step();
        relink_i = 1'b0;
        check_eq("relink1_state", {29'd0, state_o}, 32'd0);
        check_eq("relink1_retry", {28'd0, retry_cnt_o}, 32'd0);
        for (int a = 1; a <= 3; a++) begin
            n = 0;
            while (retry_cnt_o != 4'(a) && n < 1000) begin step(); n++; end
            check_eq($sformatf("nolock_attempt%0d_len", a), n, 32'd80);
            check_eq($sformatf("nolock_attempt%0d_state", a), {29'd0, state_o},
                     (a == 3) ? 32'd5 : 32'd0);
        end
        repeat (20) step();
        check_eq("fail_state", {29'd0, state_o}, 32'd5);
        check_eq("fail_flag", {31'd0, link_fail_o}, 32'd1);
        check_eq("fail_gt_rst", {31'd0, gt_rst_o}, 32'd1);
        check_eq("fail_aur_rst", {31'd0, aurora_rst_o}, 32'd1);
        check_eq("fail_retry", {28'd0, retry_cnt_o}, 32'd3);
        check_eq("fail_ready", {31'd0, link_ready_o}, 32'd0);

        // Relink out of FAIL, then a nominal bring-up
        relink_i = 1'b1;
        step();
        relink_i = 1'b0;
        check_eq("relink2_state", {29'd0, state_o}, 32'd0);
        check_eq("relink2_retry", {28'd0, retry_cnt_o}, 32'd0);
        check_eq("relink2_fail", {31'd0, link_fail_o}, 32'd0);
        bring_up("relink");

        // Reset pulse during WAIT_UP
        channel_up_i = 1'b0;
        relink_i     = 1'b1;
        step();
        relink_i = 1'b0;
        n = 0;
        while (state_o != 3'd3 && n < 1000) begin step(); n++; end
        check_eq("to_wait_up_len", n, 32'd49);
        repeat (5) step();
        nrst_i = 1'b0;
        #1;
        check_eq("mid_rst_state", {29'd0, state_o}, 32'd0);
        check_eq("mid_rst_gt_rst", {31'd0, gt_rst_o}, 32'd1);
        check_eq("mid_rst_aur_rst", {31'd0, aurora_rst_o}, 32'd1);
        check_eq("mid_rst_ready", {31'd0, link_ready_o}, 32'd0);
        check_eq("mid_rst_retry", {28'd0, retry_cnt_o}, 32'd0);
        pll_lock_i = 1'b0;
        @(posedge clk_100m);
        @(negedge clk_100m);
        nrst_i = 1'b1;
        bring_up("rst");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
